// File: rtl/stack_exec.sv
// Execute sequencer for the tiny_cpu data stack: accepts one instruction at a time,
// drives the stack's push/pop/d ports and keeps a shadow depth to catch over/underflow.
module stack_exec #(
    parameter int WIDTH     = 16,
    parameter int DEPTH_MAX = 15
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             instr_valid_i,
    output logic             instr_ready_o,
    input  logic [3:0]       opcode_i,
    input  logic [WIDTH-1:0] imm_i,
    output logic             stk_push_o,
    output logic             stk_pop_o,
    output logic             stk_load_o,
    output logic [WIDTH-1:0] stk_d_o,
    input  logic [WIDTH-1:0] stk_qtop_i,
    input  logic [WIDTH-1:0] stk_qnext_i,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic [3:0]       depth_o,
    output logic             busy_o,
    output logic             err_ovf_o,
    output logic             err_unf_o,
    output logic             err_ill_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_POP1  = 3'd1;
    localparam logic [2:0] S_POP2  = 3'd2;
    localparam logic [2:0] S_PUSH1 = 3'd3;
    localparam logic [2:0] S_PUSH2 = 3'd4;
    localparam logic [2:0] S_WAIT  = 3'd5;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_PUSHI = 4'h1;
    localparam logic [3:0] OP_POP   = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_XOR   = 4'h7;
    localparam logic [3:0] OP_DUP   = 4'h8;
    localparam logic [3:0] OP_SWAP  = 4'h9;
    localparam logic [3:0] OP_OUT   = 4'hA;

    localparam logic [3:0] DMAX = 4'(DEPTH_MAX);

    logic [2:0]       state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       depth_q, depth_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             err_ovf_q, err_ovf_d;
    logic             err_unf_q, err_unf_d;
    logic             err_ill_q, err_ill_d;

    logic             accept;
    logic             need1, need2, grows, ill;
    logic             unf, ovf, ok;
    logic [WIDTH-1:0] alu;

    assign accept = instr_valid_i && (state_q == S_IDLE);

    always_comb begin
        need1 = 1'b0;
        need2 = 1'b0;
        grows = 1'b0;
        ill   = 1'b0;
        alu   = '0;
        case (opcode_i)
            OP_NOP:   ;
            OP_PUSHI: grows = 1'b1;
            OP_POP:   need1 = 1'b1;
            OP_ADD:   begin need2 = 1'b1; alu = stk_qnext_i + stk_qtop_i; end
            OP_SUB:   begin need2 = 1'b1; alu = stk_qnext_i - stk_qtop_i; end
            OP_AND:   begin need2 = 1'b1; alu = stk_qnext_i & stk_qtop_i; end
            OP_OR:    begin need2 = 1'b1; alu = stk_qnext_i | stk_qtop_i; end
            OP_XOR:   begin need2 = 1'b1; alu = stk_qnext_i ^ stk_qtop_i; end
            OP_DUP:   begin need1 = 1'b1; grows = 1'b1; end
            OP_SWAP:  need2 = 1'b1;
            OP_OUT:   need1 = 1'b1;
            default:  ill = 1'b1;
        endcase
    end

    assign unf = (need1 && depth_q == 4'd0) || (need2 && depth_q < 4'd2);
    assign ovf = grows && (depth_q == DMAX);
    assign ok  = accept && !unf && !ovf && !ill;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        r_d         = r_q;
        b_d         = b_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        err_ovf_d   = err_ovf_q | (accept && ovf);
        err_unf_d   = err_unf_q | (accept && unf);
        err_ill_d   = err_ill_q | (accept && ill);
        depth_d     = depth_q + {3'b000, stk_push_o} - {3'b000, stk_pop_o};
        case (state_q)
            S_IDLE: begin
                if (ok) begin
                    op_d = opcode_i;
                    b_d  = stk_qnext_i;
                    case (opcode_i)
                        OP_PUSHI: begin r_d = imm_i;      state_d = S_PUSH1; end
                        OP_DUP:   begin r_d = stk_qtop_i; state_d = S_PUSH1; end
                        OP_POP:   state_d = S_POP1;
                        OP_SWAP:  begin r_d = stk_qtop_i; state_d = S_POP1; end
                        OP_OUT:   begin out_valid_d = 1'b1; out_data_d = stk_qtop_i; end
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                            r_d     = alu;
                            state_d = S_POP1;
                        end
                        default: ;
                    endcase
                end
            end
            S_POP1:  state_d = (op_q == OP_POP) ? S_WAIT : S_POP2;
            S_POP2:  state_d = S_PUSH1;
            S_PUSH1: state_d = (op_q == OP_SWAP) ? S_PUSH2 : S_WAIT;
            S_PUSH2: state_d = S_WAIT;
            S_WAIT:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            op_q        <= OP_NOP;
            r_q         <= '0;
            b_q         <= '0;
            depth_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_ovf_q   <= 1'b0;
            err_unf_q   <= 1'b0;
            err_ill_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            r_q         <= r_d;
            b_q         <= b_d;
            depth_q     <= depth_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_ovf_q   <= err_ovf_d;
            err_unf_q   <= err_unf_d;
            err_ill_q   <= err_ill_d;
        end
    end

    // PUSH1 carries the result (or old top for SWAP), PUSH2 the old second entry
    assign stk_pop_o     = (state_q == S_POP1) || (state_q == S_POP2);
    assign stk_push_o    = (state_q == S_PUSH1) || (state_q == S_PUSH2);
    assign stk_load_o    = 1'b0;
    assign stk_d_o       = (state_q == S_PUSH1) ? r_q :
                           (state_q == S_PUSH2) ? b_q : '0;
    assign instr_ready_o = (state_q == S_IDLE);
    assign busy_o        = !instr_ready_o;
    assign out_valid_o   = out_valid_q;
    assign out_data_o    = out_data_q;
    assign depth_o       = depth_q;
    assign err_ovf_o     = err_ovf_q;
    assign err_unf_o     = err_unf_q;
    assign err_ill_o     = err_ill_q;

endmodule
